// File: rtl/vga_rx_monitor.sv
// rtl/vga_rx_monitor.sv - TinyVGA receive monitor: timing lock, pixel coordinates, frame CRC
//
// Optional feature macro: VGA_RX_CRC_EN builds the per-frame CRC-16-CCITT;
// without it frame_crc is tied to 0.
//
// Ports:
//   clk          pixel clock (same clock as the video source)
//   rst_n        synchronous active-low reset
//   vga_in[7:0]  {hsync,B0,G0,R0,vsync,B1,G1,R1}, syncs active-low
//   locked       FSM is in LOCKED
//   pix_valid    active pixel while locked; qualifies x, y, rgb
//   x, y         recovered pixel coordinates
//   rgb          {R1,R0,G1,G0,B1,B0} of the pixel
//   frame_done   one-cycle pulse at each vsync rise while locked
//   h_total      last measured line period in cycles
//   v_total      last measured frame length in lines
//   err          one-cycle pulse on loss of lock
//   frame_crc    CRC of the last complete locked frame

module vga_rx_monitor #(
  parameter int H_BACK   = 48,
  parameter int H_ACTIVE = 640,
  parameter int V_BACK   = 33,
  parameter int V_ACTIVE = 480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  vga_in,
  output logic        locked,
  output logic        pix_valid,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic [5:0]  rgb,
  output logic        frame_done,
  output logic [9:0]  h_total,
  output logic [9:0]  v_total,
  output logic        err,
  output logic [15:0] frame_crc
);

  localparam logic [9:0] H_START = 10'(H_BACK);
  localparam logic [9:0] H_END   = 10'(H_BACK + H_ACTIVE);
  localparam logic [9:0] V_START = 10'(V_BACK);
  localparam logic [9:0] V_END   = 10'(V_BACK + V_ACTIVE);
  localparam logic [9:0] CNT_MAX = 10'd1023;

  typedef enum logic [1:0] {SEARCH, MEASURE, VERIFY, LOCKED} state_t;
  state_t state;

  logic [7:0] s1;
  logic       hs_prev, vs_prev;
  logic [9:0] hcnt_q, line_q, hcnt, line, h_meas;
  logic [9:0] h_ref, v_ref;
  logic       h_ref_ok, h_flag;
  logic       h_rise, v_rise, h_bad, timeout, active;
  logic [5:0] pix_rgb;

  assign h_rise  = s1[7] & ~hs_prev;
  assign v_rise  = s1[3] & ~vs_prev;
  assign pix_rgb = {s1[0], s1[4], s1[1], s1[5], s1[2], s1[6]};
  // hcnt_q holds the last count of the line that is ending, so +1 is its period
  assign h_meas  = hcnt_q + 10'd1;
  assign timeout = (hcnt == CNT_MAX);
  assign h_bad   = h_rise & h_ref_ok & (h_meas != h_ref);
  assign active  = (hcnt >= H_START) && (hcnt < H_END) &&
                   (line >= V_START) && (line < V_END);

  // Counters are resolved combinationally so they line up with the pixel in s1;
  // a coincident vsync edge clears the line count before hsync increments it.
  always_comb begin
    hcnt = hcnt_q;
    if (h_rise)
      hcnt = '0;
    else if (hcnt_q != CNT_MAX)
      hcnt = hcnt_q + 10'd1;
    line = v_rise ? '0 : line_q;
    if (h_rise && line != CNT_MAX)
      line = line + 10'd1;
  end

  // Sync registers reset to the idle (high) level so release never fakes an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1      <= 8'h88;
      hs_prev <= 1'b1;
      vs_prev <= 1'b1;
      hcnt_q  <= '0;
      line_q  <= '0;
      h_total <= '0;
      v_total <= '0;
    end else begin
      s1      <= vga_in;
      hs_prev <= s1[7];
      vs_prev <= s1[3];
      hcnt_q  <= hcnt;
      line_q  <= line;
      if (h_rise) h_total <= h_meas;
      if (v_rise) v_total <= line_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= SEARCH;
      locked     <= 1'b0;
      err        <= 1'b0;
      frame_done <= 1'b0;
      h_ref      <= '0;
      v_ref      <= '0;
      h_ref_ok   <= 1'b0;
      h_flag     <= 1'b0;
    end else begin
      err        <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        SEARCH: begin
          if (v_rise) begin
            state    <= MEASURE;
            h_ref_ok <= 1'b0;
            h_flag   <= 1'b0;
          end
        end
        MEASURE: begin
          if (h_rise && !h_ref_ok) begin
            h_ref    <= h_meas;
            h_ref_ok <= 1'b1;
          end
          if (h_bad) h_flag <= 1'b1;
          if (timeout) begin
            state <= SEARCH;
          end else if (v_rise) begin
            v_ref  <= line_q;
            h_flag <= 1'b0;
            // a frame with no complete line gives no usable h_ref
            state  <= (h_flag || h_bad || !h_ref_ok) ? SEARCH : VERIFY;
          end
        end
        VERIFY: begin
          if (h_bad) h_flag <= 1'b1;
          if (timeout) begin
            state <= SEARCH;
          end else if (v_rise) begin
            if (!h_flag && !h_bad && line_q == v_ref) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end else begin
              state <= SEARCH;
            end
          end
        end
        LOCKED: begin
          if (v_rise) frame_done <= 1'b1;
          if (timeout || h_bad || (v_rise && line_q != v_ref)) begin
            err    <= 1'b1;
            state  <= SEARCH;
            locked <= 1'b0;
          end
        end
        default: begin
          state  <= SEARCH;
          locked <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix_valid <= 1'b0;
      x         <= '0;
      y         <= '0;
      rgb       <= '0;
    end else begin
      pix_valid <= (state == LOCKED) && active;
      if (state == LOCKED && active) begin
        x   <= hcnt - H_START;
        y   <= line - V_START;
        rgb <= pix_rgb;
      end
    end
  end

`ifdef VGA_RX_CRC_EN
  logic [15:0] crc_q, crc_next;

  // Six bits per pixel, MSB first, unrolled into one cycle.
  always_comb begin
    crc_next = crc_q;
    for (int i = 5; i >= 0; i--) begin
      if (crc_next[15] ^ pix_rgb[i])
        crc_next = {crc_next[14:0], 1'b0} ^ 16'h1021;
      else
        crc_next = {crc_next[14:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crc_q     <= 16'hFFFF;
      frame_crc <= '0;
    end else if (v_rise) begin
      if (state == LOCKED) frame_crc <= crc_q;
      crc_q <= 16'hFFFF;
    end else if (active) begin
      crc_q <= crc_next;
    end
  end
`else
  assign frame_crc = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_rx_monitor.sv
// tb/tb_vga_rx_monitor.sv - scoreboard bench for vga_rx_monitor on a reduced video timing

module tb_vga_rx_monitor;
  // 20-cycle lines, 8-line frames; active window 8x3 pixels
  localparam int HB = 4, HA = 8, VB = 2, VA = 3, HP = 20, NL = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  vga_in;
  logic        locked, pix_valid, frame_done, err;
  logic [9:0]  x, y, h_total, v_total;
  logic [5:0]  rgb;
  logic [15:0] frame_crc;

  vga_rx_monitor #(.H_BACK(HB), .H_ACTIVE(HA), .V_BACK(VB), .V_ACTIVE(VA)) dut (
    .clk(clk), .rst_n(rst_n), .vga_in(vga_in), .locked(locked), .pix_valid(pix_valid),
    .x(x), .y(y), .rgb(rgb), .frame_done(frame_done), .h_total(h_total), .v_total(v_total),
    .err(err), .frame_crc(frame_crc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] px;
    logic [9:0] py;
    logic [5:0] pc;
  } pix_t;

  pix_t        exp_q[$];
  int          total = 0, bad = 0;
  int          vs_count = 0, push_count = 0;
  int          err_seen = 0, fd_seen = 0, pix_seen = 0;
  bit          solid = 1'b0, frame_full = 1'b0, crc_exp_ok = 1'b0, fd_exp = 1'b0;
  logic [15:0] crc_run = 16'hFFFF, crc_exp = 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] crc6(input logic [15:0] c, input logic [5:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 5; i >= 0; i--)
      r = (r[15] ^ d[i]) ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  task automatic check_reset_outputs();
    check("rst_flags", 32'({locked, pix_valid, frame_done, err}), 32'd0);
    check("rst_xy", 32'({x, y}), 32'd0);
    check("rst_rgb", 32'(rgb), 32'd0);
    check("rst_totals", 32'({h_total, v_total}), 32'd0);
    check("rst_crc", 32'(frame_crc), 32'd0);
  endtask

  // Monitor: pops the scoreboard on every valid pixel and counts pulses.
  always @(negedge clk) begin : mon
    pix_t p;
    if (err === 1'b1) err_seen++;
    if (frame_done === 1'b1) fd_seen++;
    if (pix_valid === 1'b1) begin
      pix_seen++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pix_unexpected: got x=%0d y=%0d rgb=%0h expected no pixel", x, y, rgb);
      end else begin
        p = exp_q.pop_front();
        check("pix_x", 32'(x), 32'(p.px));
        check("pix_y", 32'(y), 32'(p.py));
        check("pix_rgb", 32'(rgb), 32'(p.pc));
      end
    end
  end

  // One source clock: drive column c of row r in a line of period per.
  task automatic tick(input int c, input int r, input int per);
    logic [5:0] col6;
    logic       hs, vs;
    bit         act;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      rst_n = 1'b1;
      check_reset_outputs();
    end
    act  = (c >= HB) && (c < HB + HA) && (r >= VB - 1) && (r < VB - 1 + VA);
    col6 = '0;
    if (act) col6 = solid ? 6'b111000 : 6'((c * 7 + r * 13 + 5) % 64);
    hs = (c < per - 2);
    vs = (r < NL - 2);
    vga_in = {hs, col6[0], col6[2], col6[4], vs, col6[1], col6[3], col6[5]};
    if (c == 0 && r == 0) begin
      vs_count++;
      fd_exp     = frame_full;
      crc_exp_ok = frame_full;
      if (frame_full) crc_exp = crc_run;
      frame_full = (vs_count >= 3);
      crc_run    = 16'hFFFF;
    end
    if (act && vs_count >= 3) begin
      exp_q.push_back({10'(c - HB), 10'(r - VB + 1), col6});
      crc_run = crc6(crc_run, col6);
      push_count++;
    end
  endtask

  // mode: 0 clean, 1 stretch row 5 by one cycle, 2 hold hsync high ~1100 cycles, 3 reset in row 2
  task automatic run_frame(input int mode, input int r0);
    bit err_exp;
    err_exp    = 1'b0;
    err_seen   = 0;
    fd_seen    = 0;
    pix_seen   = 0;
    push_count = 0;
    fd_exp     = 1'b0;
    for (int r = r0; r < NL; r++) begin
      int per;
      per = HP;
      if (r == 5 && mode == 1) per = HP + 1;
      if (r == 5 && mode == 2) per = 1102;
      if (r == 5 && (mode == 1 || mode == 2)) begin
        err_exp    = (vs_count >= 3);
        vs_count   = 0;
        frame_full = 1'b0;
      end
      for (int c = 0; c < per; c++) begin
        tick(c, r, per);
        if (mode == 3 && r == 2 && c == 1) begin
          rst_n      = 1'b0;
          vs_count   = 0;
          frame_full = 1'b0;
          crc_exp_ok = 1'b0;
        end
      end
    end
    check("locked", 32'(locked), 32'(vs_count >= 3));
    check("err_pulses", 32'(err_seen), 32'(err_exp));
    check("frame_done_pulses", 32'(fd_seen), 32'(fd_exp));
    check("pix_count", 32'(pix_seen), 32'(push_count));
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    if (mode == 2) check("hold_pix_valid", 32'(pix_valid), 32'd0);
    if (vs_count >= 3) begin
      check("h_total", 32'(h_total), 32'(HP));
      check("v_total", 32'(v_total), 32'(NL));
    end
`ifdef VGA_RX_CRC_EN
    if (crc_exp_ok) check("frame_crc", 32'(frame_crc), 32'(crc_exp));
`else
    check("frame_crc_off", 32'(frame_crc), 32'd0);
`endif
  endtask

  initial begin
    rst_n  = 1'b0;
    vga_in = 8'h88;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;
    run_frame(0, 6);
    repeat (4) run_frame(0, 0);
    solid = 1'b1;
    repeat (2) run_frame(0, 0);
    solid = 1'b0;
    run_frame(1, 0);
    repeat (3) run_frame(0, 0);
    run_frame(2, 0);
    repeat (3) run_frame(0, 0);
    run_frame(3, 0);
    repeat (4) run_frame(0, 0);
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
